// File: rtl/vec_dot_acc.sv
// Dot product of two VEC_LEN-element vectors streamed one pair per cycle; VEC_DOT_ACC_SIGNED_EN selects two's-complement operands.
// Latency: result/out_valid one cycle after the last element is accepted.
// Backpressure: in_ready low while a result is pending (HOLD); no bypass on the out_ready cycle.
module vec_dot_acc #(
    parameter  int VEC_LEN = 32,
    parameter  int DATA_W  = 8,
    localparam int ACC_W   = 2*DATA_W+6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              in_ready,
    output logic [5:0]        elem_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic   [ACC_W-1:0]      acc;
    logic   [ACC_W-1:0]      prod_ext;
    logic   [ACC_W-1:0]      acc_sum;
    logic   [2*DATA_W-1:0]   prod;
    logic                    accept;
    logic                    last;

`ifdef VEC_DOT_ACC_SIGNED_EN
    // Operands widened by sign extension so the truncated product is the exact signed result.
    assign prod     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) *
                      $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
`else
    assign prod     = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
    assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
`endif

    assign acc_sum   = acc + prod_ext;
    assign last      = (elem_idx == 6'(VEC_LEN-1));
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ACC: begin
                if (in_valid && !clear) begin
                    accept = 1'b1;
                    if (last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
        if (clear) begin
            state_nxt = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            elem_idx <= '0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                acc      <= '0;
                elem_idx <= '0;
            end else if (accept) begin
                if (last) begin
                    result   <= acc_sum;
                    acc      <= '0;
                    elem_idx <= '0;
                end else begin
                    acc      <= acc_sum;
                    elem_idx <= elem_idx + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_dot_acc.sv
// Randomized scoreboard bench for vec_dot_acc; set VEC_DOT_ACC_SIGNED_EN to match the RTL build.
module tb_vec_dot_acc;

    localparam int VEC_LEN = 32;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 2*DATA_W+6;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              in_ready;
    logic [5:0]        elem_idx;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;

    vec_dot_acc #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_ready  (in_ready),
        .elem_idx  (elem_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [ACC_W-1:0] expq[$];
    int               cur_a[$];
    int               cur_b[$];
    logic [ACC_W-1:0] last_exp = '0;
    bit               auto_rdy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int elem_val(input logic [DATA_W-1:0] v);
`ifdef VEC_DOT_ACC_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_rdy) out_ready = ($urandom_range(0, 1) == 1);
    endtask

    // Reference: collect the vector, then take the plain sum of products modulo 2^ACC_W.
    task automatic model_accept(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                output bit complete);
        longint s;
        logic [63:0] s_bits;
        cur_a.push_back(elem_val(a));
        cur_b.push_back(elem_val(b));
        complete = 1'b0;
        if (cur_a.size() == VEC_LEN) begin
            s = 0;
            foreach (cur_a[i]) s += longint'(cur_a[i]) * longint'(cur_b[i]);
            s_bits   = s;
            last_exp = s_bits[ACC_W-1:0];
            expq.push_back(last_exp);
            cur_a.delete();
            cur_b.delete();
            complete = 1'b1;
        end
    endtask

    task automatic send_elem(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input int gap_pct);
        int waited = 0;
        bit done   = 1'b0;
        bit complete;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        while (!done) begin
            if (in_ready) begin
                check("elem_idx", elem_idx, cur_a.size());
                model_accept(a, b, complete);
                tick();
                in_valid = 1'b0;
                done     = 1'b1;
                if (complete) begin
                    check("latency_out_valid", out_valid, 1);
                    check("idx_wrap", elem_idx, 0);
                    check("in_ready_hold", in_ready, 0);
                end
            end else begin
                waited++;
                if (waited > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", waited);
                    in_valid = 1'b0;
                    done     = 1'b1;
                end else begin
                    tick();
                end
            end
        end
    endtask

    // kind: 0 ones, 1 all 0xFF, 2 random, 3 0x80*0x80, 4 0xFF*1
    task automatic run_vec(input int kind, input int gap_pct, input int n);
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       begin a = 8'd1;   b = 8'd1;   end
                1:       begin a = 8'hFF;  b = 8'hFF;  end
                3:       begin a = 8'h80;  b = 8'h80;  end
                4:       begin a = 8'hFF;  b = 8'd1;   end
                default: begin a = DATA_W'($urandom); b = DATA_W'($urandom); end
            endcase
            send_elem(a, b, gap_pct);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_elem_idx"},  elem_idx,  0);
        check({tag, "_result"},    result,    0);
    endtask

    initial begin
        logic [ACC_W-1:0] prev;
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        out_ready = 1'b0;

        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog expired");
            end
            forever begin
                @(negedge clk);
                if (!rst && !clear && out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0d with no result expected", result);
                    end else begin
                        check("result", result, expq.pop_front());
                    end
                end
            end
        join_none

        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Unit vectors with out_ready held high.
        out_ready = 1'b1;
        run_vec(0, 0, VEC_LEN);
        tick();
`ifdef VEC_DOT_ACC_SIGNED_EN
        run_vec(3, 0, VEC_LEN);
        tick();
        run_vec(4, 0, VEC_LEN);
        tick();
`else
        run_vec(1, 0, VEC_LEN);
        tick();
`endif

        auto_rdy = 1'b1;
        repeat (3) run_vec(2, 30, VEC_LEN);
        auto_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Result held for five cycles with out_ready low; inputs offered but refused.
        out_ready = 1'b0;
        run_vec(2, 0, VEC_LEN);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready",  in_ready,  0);
            check("hold_result",    result,    last_exp);
            check("hold_elem_idx",  elem_idx,  0);
            tick();
        end
        out_ready = 1'b1;
        check("no_bypass_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready",  in_ready,  1);
        check("release_elem_idx",  elem_idx,  0);
        check("release_result",    result,    last_exp);

        // Clear mid-vector overrides an offered element.
        run_vec(2, 0, 10);
        check("pre_clear_idx", elem_idx, 10);
        clear    = 1'b1;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        cur_a.delete();
        cur_b.delete();
        check("clear_idx",      elem_idx, 0);
        check("clear_in_ready", in_ready, 1);
        run_vec(0, 0, VEC_LEN);
        tick();

        // Clear in HOLD overrides out_ready and keeps the old result visible.
        out_ready = 1'b0;
        run_vec(2, 10, VEC_LEN);
        prev      = last_exp;
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        expq.delete();
        check("clear_hold_out_valid", out_valid, 0);
        check("clear_hold_in_ready",  in_ready,  1);
        check("clear_hold_result",    result,    prev);

        // Reset at elem_idx 17 with gaps.
        auto_rdy = 1'b1;
        run_vec(2, 40, 17);
        check("pre_rst_idx", elem_idx, 17);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        cur_a.delete();
        cur_b.delete();
        check_reset_state("rst_mid");

        // Reset while a result is pending.
        auto_rdy  = 1'b0;
        out_ready = 1'b0;
        run_vec(2, 20, VEC_LEN);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        expq.delete();
        check_reset_state("rst_hold");

        auto_rdy = 1'b1;
        run_vec(2, 25, VEC_LEN);
        run_vec(2, 25, VEC_LEN);
        auto_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_dot_acc.md
VEC_DOT_ACC -- requirements
Module: vec_dot_acc

Interface
REQ-001 The module SHALL have parameter VEC_LEN, default 32, elements per vector (legal 2..64).
REQ-002 The module SHALL have parameter DATA_W, default 8, operand width in bits.
REQ-003 The module SHALL use ACC_W = 2*DATA_W+6 as the result width (22 at defaults).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clear  input  1  synchronous abort of the current vector.
REQ-007 in_valid  input  1  the a_in/b_in element pair is valid.
REQ-008 a_in  input  DATA_W  operand A element.
REQ-009 b_in  input  DATA_W  operand B element.
REQ-010 in_ready  output  1  the block accepts an element this cycle.
REQ-011 elem_idx  output  6  index of the next element to be accepted (0..VEC_LEN-1).
REQ-012 out_valid  output  1  result holds a completed dot product.
REQ-013 out_ready  input  1  the downstream stage accepts the result.
REQ-014 result  output  ACC_W  completed dot product.

Function
REQ-015 The module SHALL implement a two-state FSM: ACC (accumulating) and HOLD (result pending).
REQ-016 The module SHALL drive in_ready = 1 exactly when the state is ACC; an element is accepted when in_valid && in_ready.
REQ-017 On each accepted element, the module SHALL add a_in*b_in, extended to ACC_W, to the accumulator and increment elem_idx by 1.
REQ-018 When the accepted element has elem_idx == VEC_LEN-1, the module SHALL register accumulator+product into result, set out_valid the next cycle, clear the accumulator and elem_idx to 0, and enter HOLD.
REQ-019 Latency SHALL be 1 cycle from acceptance of the last element to out_valid=1.
REQ-020 In HOLD, result and out_valid SHALL hold stable until out_ready=1; on that cycle out_valid SHALL clear and the state SHALL return to ACC.
REQ-021 The module SHALL NOT bypass from HOLD: in_ready SHALL be 0 during the cycle in which out_ready is accepted, so the next element is accepted no earlier than the following cycle.
REQ-022 When in_valid=0 in ACC, the accumulator and elem_idx SHALL hold their values; gaps of any length SHALL be allowed.
REQ-023 Arithmetic SHALL wrap modulo 2^ACC_W, and ACC_W SHALL be wide enough that no overflow occurs for VEC_LEN <= 64.
REQ-024 clear=1 SHALL zero the accumulator and elem_idx, drop out_valid, and force ACC; clear SHALL override in_valid and out_ready in the same cycle.
REQ-025 result SHALL retain its last value after out_valid clears and SHALL change only at REQ-018 or on reset.

Reset
REQ-026 rst=1 at a clock edge SHALL set state=ACC, accumulator=0, elem_idx=0, out_valid=0 and result=0, and rst SHALL take priority over clear and all other inputs.
REQ-027 rst asserted mid-vector or in HOLD SHALL discard all partial and pending results, and the first element accepted after rst deasserts SHALL be index 0.

Configuration
REQ-028 With macro VEC_DOT_ACC_SIGNED_EN defined, a_in and b_in SHALL be two's complement, and the product SHALL be sign-extended to ACC_W.
REQ-029 Without VEC_DOT_ACC_SIGNED_EN, the operands SHALL be unsigned, and the product SHALL be zero-extended to ACC_W.

Verification
REQ-030 Unsigned, 32 accepts with a=b=1 and out_ready=1 -> out_valid=1 one cycle after the 32nd accept, result=32, elem_idx=0.
REQ-031 Unsigned, 32 accepts with a=b=255 -> result=2080800 (22'h1FC020), with no overflow.
REQ-032 Signed, 32 accepts with a=8'h80, b=8'h80 -> result=524288; then 32 accepts with a=8'hFF, b=1 -> result=22'h3FFFE0 (-32).
REQ-033 out_ready=0 for 5 cycles after completion -> result and out_valid stable, in_ready=0, no element accepted; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
REQ-034 clear after 10 accepts, then 32 accepts with a=b=1 -> result=32 and elem_idx counts 0..31; clear in HOLD -> out_valid drops next cycle.
REQ-035 rst asserted in HOLD and at elem_idx=17, with random in_valid gaps -> all outputs return to the REQ-026 values, and the next vector's result is correct.
